// File: rtl/fft_bitrev_reorder_if.sv
// Streaming bus for the FFT bit-reverse reorder buffer.
// Carries the input sample stream (bit-reversed bin order) and the output
// sample stream (natural bin order), each with a valid/ready handshake.
//   in_valid/in_ready/in_re/in_im          : sample stream into the buffer
//   out_valid/out_ready/out_re/out_im/out_last : sample stream out of the buffer
// The master modport is the environment around the block; the slave modport
// is the reorder buffer itself.
interface fft_bitrev_reorder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_re;
    logic [WIDTH-1:0] in_im;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_re;
    logic [WIDTH-1:0] out_im;
    logic             out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer at the tail of the radix-2 SDF FFT pipeline.
// Each frame of N = 2**LOG2N complex samples arrives in bit-reversed bin
// order and is written into one bank of a ping-pong buffer at the
// bit-reversed address; the bank is then read back in natural order 0..N-1.
// While one bank is being read the other can be filled.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fft_bitrev_reorder_if (input and output streams)
module fft_bitrev_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_bitrev_reorder_if.slave   bus
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] CNT_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};

    // Reverse the bit order of a frame index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Both banks in one array; the top address bit selects the bank.
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    logic             wsel_r;
    logic             rsel_r;
    logic [LOG2N-1:0] wcnt_r;
    logic [LOG2N-1:0] rcnt_r;
    logic [1:0]       full_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [WIDTH-1:0] out_re_r;
    logic [WIDTH-1:0] out_im_r;

    logic             in_ready_s;
    logic             wr_fire_s;
    logic             wr_last_s;
    logic             rd_load_s;
    logic             rd_last_s;
    logic [1:0]       full_nxt_s;
    logic [2*WIDTH-1:0] rd_word_s;

    // Handshake decode and per-bank full flag update. The writer only sets a
    // bank that is not full and the reader only clears a bank that is full,
    // so set and clear never collide on the same bank.
    always_comb begin
        in_ready_s = ~full_r[wsel_r];
        wr_fire_s  = bus.in_valid && in_ready_s;
        wr_last_s  = wr_fire_s && (wcnt_r == CNT_LAST);
        rd_load_s  = full_r[rsel_r] && (!out_valid_r || bus.out_ready);
        rd_last_s  = rd_load_s && (rcnt_r == CNT_LAST);
        rd_word_s  = mem[{rsel_r, rcnt_r}];
        full_nxt_s = full_r;
        for (int b = 0; b < 2; b++) begin
            full_nxt_s[b] = (full_r[b] | (wr_last_s && (wsel_r == b[0])))
                          & ~(rd_last_s && (rsel_r == b[0]));
        end
    end

    // Sample storage: written at the bit-reversed address, never reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem[{wsel_r, bitrev(wcnt_r)}] <= {bus.in_re, bus.in_im};
        end
    end

    // Write pointer: advance per accepted sample, swap banks at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel_r <= 1'b0;
            wcnt_r <= '0;
        end else if (wr_fire_s) begin
            wcnt_r <= wcnt_r + CNT_ONE;
            if (wr_last_s) begin
                wsel_r <= ~wsel_r;
            end
        end
    end

    // Bank full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
        end
    end

    // Read pointer and output register; data holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsel_r      <= 1'b0;
            rcnt_r      <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_re_r    <= '0;
            out_im_r    <= '0;
        end else if (rd_load_s) begin
            out_re_r    <= rd_word_s[2*WIDTH-1:WIDTH];
            out_im_r    <= rd_word_s[WIDTH-1:0];
            out_valid_r <= 1'b1;
            out_last_r  <= (rcnt_r == CNT_LAST);
            rcnt_r      <= rcnt_r + CNT_ONE;
            if (rd_last_s) begin
                rsel_r <= ~rsel_r;
            end
        end else if (bus.out_ready && out_valid_r) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_re    = out_re_r;
    assign bus.out_im    = out_im_r;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
    } exp_t;

    typedef struct {
        int           bin;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
    } spot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.WIDTH(W)) bus ();

    fft_bitrev_reorder #(.WIDTH(W), .LOG2N(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    exp_t sb[$];
    logic [W-1:0] fr_re [64];
    logic [W-1:0] fr_im [64];
    int fcnt = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int mode = 0;
    int seq = 0;
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;

    bit cap_en = 1'b0;
    int cap_n = 0;
    logic [W-1:0] cap_re [64];
    logic [W-1:0] cap_im [64];
    logic         cap_last [64];

    bit win = 1'b0;
    int first_x = -1;
    int last_x = -1;

    logic         hold_v = 1'b0;
    logic [W-1:0] hold_re, hold_im;
    logic         hold_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int rev6(input int x);
        int r = 0;
        for (int b = 0; b < 6; b++) if ((x & (1 << b)) != 0) r |= (32 >> b);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready driver: either forced level or 50% random
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            fcnt = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("hold_stable", {bus.out_re, bus.out_im, bus.out_last},
                      {hold_re, hold_im, hold_last});
            hold_v = bus.out_valid && !bus.out_ready;
            hold_re = bus.out_re;
            hold_im = bus.out_im;
            hold_last = bus.out_last;

            if (bus.in_valid && bus.in_ready) begin
                fr_re[fcnt] = bus.in_re;
                fr_im[fcnt] = bus.in_im;
                fcnt++;
                acc_cnt++;
                if (fcnt == 64) begin
                    for (int j = 0; j < 64; j++) begin
                        exp_t e;
                        e.re = fr_re[rev6(j)];
                        e.im = fr_im[rev6(j)];
                        e.last = (j == 63);
                        sb.push_back(e);
                    end
                    fcnt = 0;
                end
            end

            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                if (win) begin
                    if (first_x < 0) first_x = cyc;
                    last_x = cyc;
                end
                if (cap_en && cap_n < 64) begin
                    cap_re[cap_n] = bus.out_re;
                    cap_im[cap_n] = bus.out_im;
                    cap_last[cap_n] = bus.out_last;
                    cap_n++;
                end
                check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_sample", {bus.out_re, bus.out_im, bus.out_last},
                          {e.re, e.im, e.last});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive samples until n accepted or max_cyc cycles elapse.
    task automatic drive(input int n, input bit rnd, input int max_cyc, output int got);
        int c = 0;
        got = 0;
        while (got < n && c < max_cyc) begin
            int k;
            k = seq % 64;
            bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            case (mode)
                0: begin bus.in_re = 16'(k); bus.in_im = 16'(-k); end
                1: begin bus.in_re = 16'($urandom); bus.in_im = 16'($urandom); end
                2: begin
                    bus.in_re = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
                    bus.in_im = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
                end
                default: begin bus.in_re = 16'h0000; bus.in_im = 16'h0000; end
            endcase
            @(negedge clk);
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            if (bus.in_valid && bus.in_ready) begin
                got++;
                seq++;
            end
            @(posedge clk);
            #1;
            c++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((sb.size() != 0 || bus.out_valid) && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    spot_t spots [8];
    spot_t ext_spots [4];

    initial begin
        int got;
        int base;

        spots[0] = '{0,  16'h0000, 16'h0000, 1'b0};
        spots[1] = '{1,  16'h0020, 16'hFFE0, 1'b0};
        spots[2] = '{2,  16'h0010, 16'hFFF0, 1'b0};
        spots[3] = '{5,  16'h0028, 16'hFFD8, 1'b0};
        spots[4] = '{10, 16'h0014, 16'hFFEC, 1'b0};
        spots[5] = '{32, 16'h0001, 16'hFFFF, 1'b0};
        spots[6] = '{62, 16'h001F, 16'hFFE1, 1'b0};
        spots[7] = '{63, 16'h003F, 16'hFFC1, 1'b1};
        ext_spots[0] = '{0,  16'h8000, 16'h7FFF, 1'b0};
        ext_spots[1] = '{1,  16'h8000, 16'h7FFF, 1'b0};
        ext_spots[2] = '{32, 16'h7FFF, 16'h8000, 1'b0};
        ext_spots[3] = '{63, 16'h7FFF, 16'h8000, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_re = 16'h0000;
        bus.in_im = 16'h0000;

        // Reset state
        cycles(3);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_data", {bus.out_re, bus.out_im}, 64'd0);
        rst_n = 1'b1;
        cycles(1);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Ramp frame, natural-order spot checks
        mode = 0; seq = 0; cap_en = 1'b1; cap_n = 0;
        drive(64, 1'b0, 500, got);
        check("t1_accepted", 64'(got), 64'd64);
        wait_drain();
        cap_en = 1'b0;
        check("t1_captured", 64'(cap_n), 64'd64);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_bin%0d", spots[i].bin),
                  {cap_re[spots[i].bin], cap_im[spots[i].bin], cap_last[spots[i].bin]},
                  {spots[i].re, spots[i].im, spots[i].last});
        end
        begin
            int nl = 0;
            for (int j = 0; j < 64; j++) if (cap_last[j]) nl++;
            check("t1_last_count", 64'(nl), 64'd1);
        end

        // Three back-to-back frames, no bubbles
        mode = 1; win = 1'b1; first_x = -1; stall_cnt = 0; base = out_cnt;
        drive(192, 1'b0, 400, got);
        check("t2_accepted", 64'(got), 64'd192);
        wait_drain();
        win = 1'b0;
        check("t2_in_stalls", 64'(stall_cnt), 64'd0);
        check("t2_out_count", 64'(out_cnt - base), 64'd192);
        check("t2_out_span", 64'(last_x - first_x), 64'd191);

        // Backpressure: both banks fill, then drain
        rdy_force = 1'b0;
        cycles(2);
        base = acc_cnt;
        drive(1000, 1'b0, 200, got);
        check("t3_accepted", 64'(got), 64'd128);
        check("t3_acc_cnt", 64'(acc_cnt - base), 64'd128);
        check("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("t3_out_valid_held", 64'(bus.out_valid), 64'd1);
        rdy_force = 1'b1;
        wait_drain();

        // Random valid/ready over 20 frames
        rdy_rand = 1'b1; base = out_cnt;
        drive(1280, 1'b1, 20000, got);
        check("t4_accepted", 64'(got), 64'd1280);
        rdy_rand = 1'b0; rdy_force = 1'b1;
        wait_drain();
        check("t4_out_count", 64'(out_cnt - base), 64'd1280);

        // Reset with one full bank and a partial frame in flight
        rdy_force = 1'b0;
        cycles(2);
        mode = 0;
        drive(101, 1'b0, 300, got);
        check("t5_accepted", 64'(got), 64'd101);
        rst_n = 1'b0;
        sb.delete();
        seq = 0;
        @(negedge clk);
        check("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_rst_out_last", 64'(bus.out_last), 64'd0);
        check("t5_rst_out_data", {bus.out_re, bus.out_im}, 64'd0);
        cycles(2);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        cycles(3);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        check("t5_no_stale", 64'(bus.out_valid), 64'd0);
        base = out_cnt;
        drive(64, 1'b0, 500, got);
        wait_drain();
        check("t5_out_count", 64'(out_cnt - base), 64'd64);

        // Extreme values pass through bit-exact
        mode = 2; cap_en = 1'b1; cap_n = 0;
        drive(64, 1'b0, 500, got);
        wait_drain();
        cap_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_bin%0d", ext_spots[i].bin),
                  {cap_re[ext_spots[i].bin], cap_im[ext_spots[i].bin], cap_last[ext_spots[i].bin]},
                  {ext_spots[i].re, ext_spots[i].im, ext_spots[i].last});
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
